// File: rtl/dcache_pkg.sv
// dcache_pkg: shared definitions for the dcache memory arbiter.
//   ch_state_e            per-channel FSM state
//   DEF_*                 default parameter values for the arbiter and picker
package dcache_pkg;

  localparam int unsigned DEF_ADDR_BITS     = 8;
  localparam int unsigned DEF_DATA_BITS     = 8;
  localparam int unsigned DEF_NUM_CONSUMERS = 8;
  localparam int unsigned DEF_NUM_CHANNELS  = 2;

  typedef enum logic [2:0] {
    CH_IDLE,
    CH_READ_WAIT,
    CH_WRITE_WAIT,
    CH_READ_RELAY,
    CH_WRITE_RELAY
  } ch_state_e;

endpackage

// File: rtl/dcache_rr_picker.sv
// dcache_rr_picker: masked find-first search starting at a pointer, with wrap.
//   req   in  [N]  request vector
//   mask  in  [N]  requests to ignore
//   ptr   in  [W]  index where the search starts
//   idx   out [W]  first unmasked requester at or after ptr (wrapping)
//   found out      an unmasked requester exists
module dcache_rr_picker
  import dcache_pkg::*;
#(
  parameter int unsigned N = DEF_NUM_CONSUMERS,
  localparam int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         found
);

  logic [N-1:0] elig;
  int unsigned  cand;
  logic [W-1:0] cand_idx;

  assign elig = req & ~mask;

  always_comb begin
    idx      = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand     = (32'(ptr) + i) % N;
      cand_idx = W'(cand);
      if (!found && elig[cand_idx]) begin
        idx   = cand_idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dcache_mem_arbiter.sv
// dcache_mem_arbiter: routes dcache miss/writeback requests from NUM_CONSUMERS
// requesters onto NUM_CHANNELS memory channels, one transaction per channel.
//   clk, reset                    rising-edge clock, async active-low reset
//   consumer_read_*               per-consumer read request / response
//   consumer_write_*              per-consumer write request / response
//   mem_read_*                    per-channel memory read handshake
//   mem_write_*                   per-channel memory write handshake
// Each channel: IDLE -> *_WAIT (memory handshake) -> *_RELAY (consumer
// handshake) -> IDLE. All outputs are registered.
module dcache_mem_arbiter
  import dcache_pkg::*;
#(
  parameter int unsigned ADDR_BITS     = DEF_ADDR_BITS,
  parameter int unsigned DATA_BITS     = DEF_DATA_BITS,
  parameter int unsigned NUM_CONSUMERS = DEF_NUM_CONSUMERS,
  parameter int unsigned NUM_CHANNELS  = DEF_NUM_CHANNELS
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]                  mem_read_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_read_address,
  input  logic [NUM_CHANNELS-1:0]                  mem_read_ready,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_read_data,
  output logic [NUM_CHANNELS-1:0]                  mem_write_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_write_address,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_write_data,
  input  logic [NUM_CHANNELS-1:0]                  mem_write_ready
);

  localparam int unsigned IW = $clog2(NUM_CONSUMERS);

  ch_state_e                state_q [NUM_CHANNELS];
  ch_state_e                state_d [NUM_CHANNELS];
  logic [IW-1:0]            owner_q [NUM_CHANNELS];
  logic [IW-1:0]            owner_d [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0] serving_q, serving_d;
  logic [IW-1:0]            rr_ptr_q, rr_ptr_d;

  logic [NUM_CHANNELS-1:0]                 mrv_d, mwv_d;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mra_d, mwa_d;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mwd_d;
  logic [NUM_CONSUMERS-1:0]                crr_d, cwr_d;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] crd_d;

  logic [NUM_CONSUMERS-1:0] req_any;
  logic                     take [NUM_CHANNELS];
  logic [IW-1:0]            pick [NUM_CHANNELS];
  logic                     any_grant;
  logic [IW-1:0]            top_grant;

  assign req_any = consumer_read_valid | consumer_write_valid;

  // Channels pick in ascending order: each picker sees the serving mask plus
  // every consumer already taken by a lower idle channel this cycle.
  for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_ch
    logic [NUM_CONSUMERS-1:0] mask_in;
    logic [NUM_CONSUMERS-1:0] mask_out;
    logic [IW-1:0]            idx;
    logic                     found;

    if (ch == 0) begin : g_head
      assign mask_in = serving_q;
    end else begin : g_tail
      assign mask_in = g_ch[ch-1].mask_out;
    end

    dcache_rr_picker #(.N(NUM_CONSUMERS)) u_picker (
      .req   (req_any),
      .mask  (mask_in),
      .ptr   (rr_ptr_q),
      .idx   (idx),
      .found (found)
    );

    assign take[ch]  = found && (state_q[ch] == CH_IDLE);
    assign pick[ch]  = idx;
    assign mask_out  = mask_in | (take[ch] ? (NUM_CONSUMERS'(1) << idx) : '0);
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    serving_d = serving_q;
    rr_ptr_d  = rr_ptr_q;
    mrv_d     = mem_read_valid;
    mra_d     = mem_read_address;
    mwv_d     = mem_write_valid;
    mwa_d     = mem_write_address;
    mwd_d     = mem_write_data;
    crr_d     = consumer_read_ready;
    crd_d     = consumer_read_data;
    cwr_d     = consumer_write_ready;
    any_grant = 1'b0;
    top_grant = '0;

    for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
      case (state_q[ch])
        CH_IDLE: begin
          if (take[ch]) begin
            owner_d[ch]         = pick[ch];
            serving_d[pick[ch]] = 1'b1;
            if (!any_grant || (pick[ch] > top_grant)) top_grant = pick[ch];
            any_grant = 1'b1;
            // Reads win when a consumer raises both; the write is picked up
            // by a later grant once the read relay has finished.
            if (consumer_read_valid[pick[ch]]) begin
              state_d[ch] = CH_READ_WAIT;
              mrv_d[ch]   = 1'b1;
              mra_d[ch]   = consumer_read_address[pick[ch]];
            end else begin
              state_d[ch] = CH_WRITE_WAIT;
              mwv_d[ch]   = 1'b1;
              mwa_d[ch]   = consumer_write_address[pick[ch]];
              mwd_d[ch]   = consumer_write_data[pick[ch]];
            end
          end
        end
        CH_READ_WAIT: begin
          if (mem_read_ready[ch]) begin
            mrv_d[ch]          = 1'b0;
            crr_d[owner_q[ch]] = 1'b1;
            crd_d[owner_q[ch]] = mem_read_data[ch];
            state_d[ch]        = CH_READ_RELAY;
          end
        end
        CH_WRITE_WAIT: begin
          if (mem_write_ready[ch]) begin
            mwv_d[ch]          = 1'b0;
            cwr_d[owner_q[ch]] = 1'b1;
            state_d[ch]        = CH_WRITE_RELAY;
          end
        end
        CH_READ_RELAY: begin
          if (!consumer_read_valid[owner_q[ch]]) begin
            crr_d[owner_q[ch]]     = 1'b0;
            serving_d[owner_q[ch]] = 1'b0;
            state_d[ch]            = CH_IDLE;
          end
        end
        CH_WRITE_RELAY: begin
          if (!consumer_write_valid[owner_q[ch]]) begin
            cwr_d[owner_q[ch]]     = 1'b0;
            serving_d[owner_q[ch]] = 1'b0;
            state_d[ch]            = CH_IDLE;
          end
        end
        default: state_d[ch] = CH_IDLE;
      endcase
    end

    if (any_grant) begin
      rr_ptr_d = (top_grant == IW'(NUM_CONSUMERS - 1)) ? '0 : top_grant + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
        state_q[ch] <= CH_IDLE;
        owner_q[ch] <= '0;
      end
      serving_q            <= '0;
      rr_ptr_q             <= '0;
      mem_read_valid       <= '0;
      mem_read_address     <= '0;
      mem_write_valid      <= '0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
      consumer_read_ready  <= '0;
      consumer_read_data   <= '0;
      consumer_write_ready <= '0;
    end else begin
      state_q              <= state_d;
      owner_q              <= owner_d;
      serving_q            <= serving_d;
      rr_ptr_q             <= rr_ptr_d;
      mem_read_valid       <= mrv_d;
      mem_read_address     <= mra_d;
      mem_write_valid      <= mwv_d;
      mem_write_address    <= mwa_d;
      mem_write_data       <= mwd_d;
      consumer_read_ready  <= crr_d;
      consumer_read_data   <= crd_d;
      consumer_write_ready <= cwr_d;
    end
  end

endmodule

// File: tb/tb_dcache_mem_arbiter.sv
// tb_dcache_mem_arbiter: directed scenarios followed by randomized traffic,
// every cycle compared against a transaction-level model of the arbiter.
module tb_dcache_mem_arbiter;

  localparam int NC = 8;
  localparam int NH = 2;
  localparam int AW = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic [NC-1:0]         rv, wv, crr, cwr;
  logic [NC-1:0][AW-1:0] ra, wa;
  logic [NC-1:0][DW-1:0] wd, crd;
  logic [NH-1:0]         mrv, mrr, mwv, mwr;
  logic [NH-1:0][AW-1:0] mra, mwa;
  logic [NH-1:0][DW-1:0] mrd, mwd;

  always #5 clk = ~clk;

  dcache_mem_arbiter #(
    .ADDR_BITS     (AW),
    .DATA_BITS     (DW),
    .NUM_CONSUMERS (NC),
    .NUM_CHANNELS  (NH)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .consumer_read_valid    (rv),
    .consumer_read_address  (ra),
    .consumer_read_ready    (crr),
    .consumer_read_data     (crd),
    .consumer_write_valid   (wv),
    .consumer_write_address (wa),
    .consumer_write_data    (wd),
    .consumer_write_ready   (cwr),
    .mem_read_valid         (mrv),
    .mem_read_address       (mra),
    .mem_read_ready         (mrr),
    .mem_read_data          (mrd),
    .mem_write_valid        (mwv),
    .mem_write_address      (mwa),
    .mem_write_data         (mwd),
    .mem_write_ready        (mwr)
  );

  // Reference model: one transaction record per channel.
  // phase 0 = free, 1 = waiting on memory, 2 = waiting on consumer to drop valid.
  typedef struct {
    int           phase;
    int           cons;
    bit           rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } xact_t;

  xact_t         xm [NH];
  bit            busy [NC];
  int            ptr_m;
  logic [DW-1:0] rdata_m [NC];

  int total  = 0;
  int passed = 0;
  int failed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int h = 0; h < NH; h++)
      xm[h] = '{phase: 0, cons: 0, rd: 1'b0, addr: '0, data: '0};
    for (int c = 0; c < NC; c++) begin
      busy[c]    = 1'b0;
      rdata_m[c] = '0;
    end
    ptr_m = 0;
  endtask

  // Advance the model across one rising edge using the inputs held at that edge.
  task automatic model_edge();
    xact_t nx [NH];
    bit    nbusy [NC];
    bit    taken [NC];
    int    hi;
    nx    = xm;
    nbusy = busy;
    hi    = -1;
    for (int c = 0; c < NC; c++) taken[c] = 1'b0;
    for (int h = 0; h < NH; h++) begin
      int c;
      bit got;
      c   = xm[h].cons;
      got = 1'b0;
      case (xm[h].phase)
        0: for (int k = 0; k < NC; k++) begin
             int cc;
             cc = (ptr_m + k) % NC;
             if (!got && !busy[cc] && !taken[cc] && (rv[cc] || wv[cc])) begin
               got       = 1'b1;
               taken[cc] = 1'b1;
               nbusy[cc] = 1'b1;
               nx[h].phase = 1;
               nx[h].cons  = cc;
               nx[h].rd    = rv[cc];
               nx[h].addr  = rv[cc] ? ra[cc] : wa[cc];
               nx[h].data  = wd[cc];
               if (cc > hi) hi = cc;
             end
           end
        1: if (xm[h].rd ? mrr[h] : mwr[h]) begin
             nx[h].phase = 2;
             if (xm[h].rd) rdata_m[c] = mrd[h];
           end
        2: if (!(xm[h].rd ? rv[c] : wv[c])) begin
             nx[h].phase = 0;
             nbusy[c]    = 1'b0;
           end
        default: ;
      endcase
    end
    if (hi >= 0) ptr_m = (hi + 1) % NC;
    xm   = nx;
    busy = nbusy;
  endtask

  task automatic check_all(input string ph);
    logic [NH-1:0]         e_mrv, e_mwv;
    logic [NC-1:0]         e_crr, e_cwr;
    logic [NC-1:0][DW-1:0] e_crd;
    e_mrv = '0;
    e_mwv = '0;
    e_crr = '0;
    e_cwr = '0;
    for (int h = 0; h < NH; h++) begin
      if (xm[h].phase == 1) begin
        if (xm[h].rd) e_mrv[h] = 1'b1; else e_mwv[h] = 1'b1;
      end
      if (xm[h].phase == 2) begin
        if (xm[h].rd) e_crr[xm[h].cons] = 1'b1; else e_cwr[xm[h].cons] = 1'b1;
      end
    end
    for (int c = 0; c < NC; c++) e_crd[c] = rdata_m[c];
    chk({ph, " mem_read_valid"}, 64'(mrv), 64'(e_mrv));
    chk({ph, " mem_write_valid"}, 64'(mwv), 64'(e_mwv));
    chk({ph, " cons_read_ready"}, 64'(crr), 64'(e_crr));
    chk({ph, " cons_write_ready"}, 64'(cwr), 64'(e_cwr));
    chk({ph, " cons_read_data"}, 64'(crd), 64'(e_crd));
    for (int h = 0; h < NH; h++) begin
      if (e_mrv[h]) chk({ph, " mem_read_address"}, 64'(mra[h]), 64'(xm[h].addr));
      if (e_mwv[h]) begin
        chk({ph, " mem_write_address"}, 64'(mwa[h]), 64'(xm[h].addr));
        chk({ph, " mem_write_data"}, 64'(mwd[h]), 64'(xm[h].data));
      end
    end
  endtask

  task automatic step(input string ph);
    @(posedge clk);
    if (reset) model_edge();
    @(negedge clk);
    check_all(ph);
  endtask

  // Consumers drop valid when they see ready; a just-finished consumer waits
  // a cycle before raising a new request.
  task automatic consumer_react(input bit allow_new);
    for (int c = 0; c < NC; c++) begin
      bit         done;
      logic [1:0] kind;
      done = 1'b0;
      if (rv[c] && crr[c]) begin rv[c] = 1'b0; done = 1'b1; end
      if (wv[c] && cwr[c]) begin wv[c] = 1'b0; done = 1'b1; end
      if (allow_new && !done && !rv[c] && !wv[c] && ($urandom_range(0, 5) == 0)) begin
        kind  = 2'($urandom_range(1, 3));
        rv[c] = kind[0];
        wv[c] = kind[1];
        ra[c] = 8'($urandom);
        wa[c] = 8'($urandom);
        wd[c] = 8'($urandom);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rv = '0; wv = '0; ra = '0; wa = '0; wd = '0;
    mrr = '0; mwr = '0; mrd = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    reset = 1'b1;
    step("idle");
    step("idle");

    // Consumer 3 read, memory answers two cycles after the grant
    rv[3] = 1'b1; ra[3] = 8'h42;
    step("rd3");
    chk("rd3 mem_read_valid0", 64'(mrv[0]), 64'(1));
    chk("rd3 mem_read_address0", 64'(mra[0]), 64'(8'h42));
    step("rd3");
    mrr[0] = 1'b1; mrd[0] = 8'hA5;
    step("rd3");
    mrr[0] = 1'b0; mrd[0] = 8'h00;
    chk("rd3 cons_read_ready3", 64'(crr[3]), 64'(1));
    chk("rd3 cons_read_data3", 64'(crd[3]), 64'(8'hA5));
    chk("rd3 mem_read_valid0 off", 64'(mrv[0]), 64'(0));
    step("rd3");
    chk("rd3 ready held", 64'(crr[3]), 64'(1));
    rv[3] = 1'b0;
    step("rd3");
    chk("rd3 ready dropped", 64'(crr[3]), 64'(0));
    chk("rd3 data held", 64'(crd[3]), 64'(8'hA5));

    // Consumer 5 write, held stable until memory accepts
    wv[5] = 1'b1; wa[5] = 8'h10; wd[5] = 8'h77;
    step("wr5");
    for (int i = 0; i < 3; i++) begin
      chk("wr5 mem_write_valid0", 64'(mwv[0]), 64'(1));
      chk("wr5 mem_write_address0", 64'(mwa[0]), 64'(8'h10));
      chk("wr5 mem_write_data0", 64'(mwd[0]), 64'(8'h77));
      if (i < 2) step("wr5");
    end
    mwr[0] = 1'b1;
    step("wr5");
    mwr[0] = 1'b0;
    chk("wr5 cons_write_ready5", 64'(cwr[5]), 64'(1));
    chk("wr5 mem_write_valid0 off", 64'(mwv[0]), 64'(0));
    wv[5] = 1'b0;
    step("wr5");
    chk("wr5 ready dropped", 64'(cwr[5]), 64'(0));

    // Consumer 7 drops valid early; memory transaction still completes
    rv[7] = 1'b1; ra[7] = 8'h70;
    step("early7");
    rv[7] = 1'b0;
    step("early7");
    chk("early7 mem_read_valid0 kept", 64'(mrv[0]), 64'(1));
    mrr[0] = 1'b1; mrd[0] = 8'h81;
    step("early7");
    mrr[0] = 1'b0;
    chk("early7 ready pulse", 64'(crr[7]), 64'(1));
    chk("early7 data", 64'(crd[7]), 64'(8'h81));
    step("early7");
    chk("early7 pulse ended", 64'(crr[7]), 64'(0));

    // Reset in the middle of a memory wait
    rv[6] = 1'b1; ra[6] = 8'h99;
    step("rst");
    step("rst");
    #2;
    reset = 1'b0;
    rv = '0;
    model_reset();
    #1;
    check_all("rst_mid");
    chk("rst_mid mem_read_valid", 64'(mrv), 64'(0));
    chk("rst_mid cons_read_data", 64'(crd), 64'(0));
    @(negedge clk);
    check_all("rst_hold");
    reset = 1'b1;
    repeat (3) step("rst_after");
    chk("rst_after mem_read_valid", 64'(mrv), 64'(0));

    // Consumers 0,1,2 read together
    rv[0] = 1'b1; ra[0] = 8'h11;
    rv[1] = 1'b1; ra[1] = 8'h22;
    rv[2] = 1'b1; ra[2] = 8'h33;
    step("trio");
    chk("trio ch0 address", 64'(mra[0]), 64'(8'h11));
    chk("trio ch1 address", 64'(mra[1]), 64'(8'h22));
    chk("trio mem_read_valid", 64'(mrv), 64'(2'b11));
    chk("trio rr_ptr", 64'(dut.rr_ptr_q), 64'(2));
    mrr[0] = 1'b1; mrd[0] = 8'h5A;
    step("trio");
    mrr[0] = 1'b0;
    rv[0] = 1'b0;
    step("trio");
    step("trio");
    chk("trio cons2 on ch0", 64'(mra[0]), 64'(8'h33));
    chk("trio ch0 valid again", 64'(mrv[0]), 64'(1));
    mrr = 2'b11; mrd[0] = 8'hC1; mrd[1] = 8'hC2;
    step("trio");
    mrr = '0;
    rv[1] = 1'b0; rv[2] = 1'b0;
    step("trio");
    step("trio");

    // Consumer 4 read and write together, plus a stray ready on idle ch1
    rv[4] = 1'b1; ra[4] = 8'h44;
    wv[4] = 1'b1; wa[4] = 8'h45; wd[4] = 8'hC3;
    step("rw4");
    chk("rw4 read first", 64'(mrv[0]), 64'(1));
    chk("rw4 no write yet", 64'(mwv), 64'(0));
    mrr[1] = 1'b1; mrd[1] = 8'hEE;
    step("rw4");
    mrr[1] = 1'b0;
    chk("rw4 stray ready ignored", 64'(crr[4]), 64'(0));
    mrr[0] = 1'b1; mrd[0] = 8'h3C;
    step("rw4");
    mrr[0] = 1'b0;
    chk("rw4 read data", 64'(crd[4]), 64'(8'h3C));
    chk("rw4 write not done", 64'(cwr[4]), 64'(0));
    rv[4] = 1'b0;
    step("rw4");
    step("rw4");
    chk("rw4 write granted", 64'(mwv[0]), 64'(1));
    chk("rw4 write address", 64'(mwa[0]), 64'(8'h45));
    mwr[0] = 1'b1;
    step("rw4");
    mwr[0] = 1'b0;
    chk("rw4 write ready", 64'(cwr[4]), 64'(1));
    wv[4] = 1'b0;
    step("rw4");

    // Randomized traffic with random (and stray) memory readiness
    for (int cyc = 0; cyc < 1500; cyc++) begin
      consumer_react(1'b1);
      for (int h = 0; h < NH; h++) begin
        mrr[h] = ($urandom_range(0, 2) == 0);
        mwr[h] = ($urandom_range(0, 2) == 0);
        mrd[h] = 8'($urandom);
      end
      step("rand");
    end

    // Drain outstanding requests within a bounded number of cycles
    n = 0;
    while (((rv != '0) || (wv != '0)) && (n < 300)) begin
      consumer_react(1'b0);
      mrr = '1;
      mwr = '1;
      for (int h = 0; h < NH; h++) mrd[h] = 8'($urandom);
      step("drain");
      n++;
    end
    chk("drain pending", 64'({rv, wv}), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
